// File: rtl/req1.sv
// 8-bit carry-select adder (ripple block 0, duplicated upper blocks muxed by carry).
// Define REQ1_OUT_REG_EN to add a registered output stage on sum/cout.
module req1 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BLOCK = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             clk,
  input  logic             rst_n
);

  localparam int unsigned NBLK = (BLOCK == 0) ? 1 : WIDTH / BLOCK;

  generate
    if (BLOCK < 1) begin : g_bad_block
      $error("req1: BLOCK must be >= 1");
    end
    if (BLOCK >= 1 && (WIDTH % BLOCK) != 0) begin : g_bad_width
      $error("req1: WIDTH must be a multiple of BLOCK");
    end
  endgenerate

  // Ripple-carry chain of full adders; returns {carry_out, slice_sum}.
  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                            input logic [BLOCK-1:0] y,
                                            input logic             ci);
    logic [BLOCK-1:0] s;
    logic             c;
    c = ci;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic [NBLK-1:0]  c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

  assign {c[0], sum_c[BLOCK-1:0]} = ripple(a[BLOCK-1:0], b[BLOCK-1:0], cin);

  // Upper blocks: precompute both carry-in cases, pick with the incoming carry.
  for (genvar k = 1; k < NBLK; k++) begin : g_sel
    logic [BLOCK:0] r0;
    logic [BLOCK:0] r1;
    assign r0 = ripple(a[k*BLOCK +: BLOCK], b[k*BLOCK +: BLOCK], 1'b0);
    assign r1 = ripple(a[k*BLOCK +: BLOCK], b[k*BLOCK +: BLOCK], 1'b1);
    assign {c[k], sum_c[k*BLOCK +: BLOCK]} = c[k-1] ? r1 : r0;
  end

  assign cout_c = c[NBLK-1];

`ifdef REQ1_OUT_REG_EN
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  assign sum_d  = sum_c;
  assign cout_d = cout_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`else
  // Clock and reset are kept as ports only; tie them off here.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign sum  = sum_c;
  assign cout = cout_c;
`endif

endmodule

// File: tb/tb_req1.sv
// Self-checking bench for req1: directed vectors plus full operand sweep
// against an arithmetic reference (a + b + cin as a 9-bit integer).
module tb_req1;

  localparam int unsigned W = 8;

  logic [W-1:0] a, b, sum;
  logic         cin, cout;
  logic         clk, rst_n;

  int n_pass  = 0;
  int n_total = 0;

  req1 #(.WIDTH(W), .BLOCK(4)) dut (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .clk  (clk),
    .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer addition, widened to W+1 bits.
  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic         ci);
    int unsigned t;
    t = int'(x) + int'(y) + int'(ci);
    return (W+1)'(t);
  endfunction

  task automatic check(input string name, input logic [W:0] exp);
    n_total++;
    if ({cout, sum} === exp) n_pass++;
    else $display("FAIL %s: got cout=%0b sum=%02h, want cout=%0b sum=%02h (a=%02h b=%02h cin=%0b)",
                  name, cout, sum, exp[W], exp[W-1:0], a, b, cin);
  endtask

  // Drive a vector and wait until the outputs reflect it.
  task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a = x; b = y; cin = ci;
`ifdef REQ1_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #2;
`endif
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W:0]   exp;
    string        name;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h05, 8'h06, 1'b0, 9'h00B, "add_5_6"};
    vecs[1] = '{8'h0A, 8'h02, 1'b0, 9'h00C, "add_a_2"};
    vecs[2] = '{8'hFE, 8'h01, 1'b1, 9'h100, "full_ripple"};
    vecs[3] = '{8'h0F, 8'h01, 1'b0, 9'h010, "block_boundary"};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, "wrap_all_ones"};

    a = 8'h05; b = 8'h06; cin = 1'b0; rst_n = 1'b0;
    #12;
`ifdef REQ1_OUT_REG_EN
    check("reset_hold", 9'h000);
    @(posedge clk); #1;
    check("reset_hold_clk", 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_capture", 9'h00B);
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(posedge clk); #1;
    check("capture_ones", 9'h1FF);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 9'h000);
    #4 rst_n = 1'b1;
    @(negedge clk);
`else
    check("comb_during_reset", 9'h00B);
    rst_n = 1'b1;
    #2;
    check("comb_after_reset", 9'h00B);
`endif

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].ci);
      check(vecs[i].name, vecs[i].exp);
      n_total++;
      if (model(vecs[i].a, vecs[i].b, vecs[i].ci) === vecs[i].exp) n_pass++;
      else $display("FAIL model_%s: model gives %03h, want %03h", vecs[i].name,
                    model(vecs[i].a, vecs[i].b, vecs[i].ci), vecs[i].exp);
    end

    // Sweep: every combination in the combinational build, a strided subset when registered.
    begin
`ifdef REQ1_OUT_REG_EN
      int step = 37;
`else
      int step = 1;
`endif
      for (int ia = 0; ia < 256; ia++) begin
        for (int ib = 0; ib < 256; ib += step) begin
          for (int ic = 0; ic < 2; ic++) begin
            apply(W'(ia), W'(ib), 1'(ic));
            check("sweep", model(W'(ia), W'(ib), 1'(ic)));
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
